// File: rtl/fft_frame_writer_if.sv
// Valid/ready/last stream carrying FFT bins into the frame writer.
interface fft_frame_writer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fft_frame_writer.sv
// Writes one FFT frame into the spectrum RAM, then holds the denoise reader's enable for one readout.
// Define FFT_BITREV_EN to store a bit-reversed-order input frame in natural bin order.
module fft_frame_writer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_HOLD    = 1032,
  parameter int GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_frame_writer_if.slave   s_if,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_waddr_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  output logic                rd_enable_o,
  output logic                frame_err_o,
  output logic [15:0]         frame_cnt_o
);

  localparam int HOLD_MAX = (RD_HOLD > GAP_CYCLES) ? RD_HOLD : GAP_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [HOLD_W-1:0] HOLD_RD  = HOLD_W'(RD_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_GAP = HOLD_W'(GAP_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {
    CAPTURE,
    DRAIN,
    READOUT,
    GAP
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                tready_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_waddr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                rd_en_q;
  logic                frame_err_q;
  logic [15:0]         frame_cnt_q;

  logic                beat;
  logic [ADDR_W-1:0]   ram_waddr_d;

  assign beat = s_if.tvalid && tready_q;

`ifdef FFT_BITREV_EN
  // Frame-length checks stay on the linear pointer; only the RAM address is reversed.
  always_comb begin
    ram_waddr_d = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      ram_waddr_d[b] = wr_ptr_q[ADDR_W-1-b];
    end
  end
`else
  assign ram_waddr_d = wr_ptr_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CAPTURE;
      wr_ptr_q    <= '0;
      hold_q      <= '0;
      tready_q    <= 1'b1;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      rd_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      ram_we_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        CAPTURE: begin
          if (beat) begin
            ram_we_q    <= 1'b1;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= s_if.tdata;
            if (wr_ptr_q == PTR_LAST) begin
              wr_ptr_q <= '0;
              if (s_if.tlast) begin
                state_q     <= READOUT;
                tready_q    <= 1'b0;
                hold_q      <= HOLD_RD;
                frame_cnt_q <= frame_cnt_q + 16'd1;
              end else begin
                state_q     <= DRAIN;
                frame_err_q <= 1'b1;
              end
            end else if (s_if.tlast) begin
              wr_ptr_q    <= '0;
              frame_err_q <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (beat && s_if.tlast) begin
            state_q <= CAPTURE;
          end
        end
        READOUT: begin
          // First READOUT cycle carries the final RAM write, so enable waits one cycle.
          if (!rd_en_q) begin
            rd_en_q <= 1'b1;
          end else if (hold_q <= HOLD_ONE) begin
            rd_en_q <= 1'b0;
            state_q <= GAP;
            hold_q  <= HOLD_GAP;
          end else begin
            hold_q <= hold_q - HOLD_ONE;
          end
        end
        GAP: begin
          if (hold_q <= HOLD_ONE) begin
            state_q  <= CAPTURE;
            tready_q <= 1'b1;
          end else begin
            hold_q <= hold_q - HOLD_ONE;
          end
        end
        default: begin
          state_q  <= CAPTURE;
          tready_q <= 1'b1;
          rd_en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.tready = tready_q;
  assign ram_we_o    = ram_we_q;
  assign ram_waddr_o = ram_waddr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign rd_enable_o = rd_en_q;
  assign frame_err_o = frame_err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_writer.sv
// Directed bench for fft_frame_writer: good/short/long frames, backpressure, gapped input and mid-frame reset.
module tb_fft_frame_writer;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int RD_HOLD    = 1032;
  localparam int GAP_CYCLES = 4;
  localparam int NBINS      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_frame_writer_if #(.DATA_W(DATA_W)) s_if ();

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              rd_enable;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  fft_frame_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_HOLD(RD_HOLD), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_if       (s_if),
    .ram_we_o   (ram_we),
    .ram_waddr_o(ram_waddr),
    .ram_wdata_o(ram_wdata),
    .rd_enable_o(rd_enable),
    .frame_err_o(frame_err),
    .frame_cnt_o(frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Observed activity, recorded mid-cycle
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  int err_total = 0;
  int rd_rises = 0;
  int rd_rise_cyc = -1;
  int rd_fall_cyc = -1;
  int tr_rise_cyc = -1;
  int we_during_rd = 0;
  logic prev_rd = 1'b0;
  logic prev_tr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wa_q.push_back(ram_waddr);
      wd_q.push_back(ram_wdata);
      if (rd_enable === 1'b1) we_during_rd <= we_during_rd + 1;
    end
    if (frame_err === 1'b1) err_total <= err_total + 1;
    if (rd_enable === 1'b1 && prev_rd !== 1'b1) begin
      rd_rises    <= rd_rises + 1;
      rd_rise_cyc <= cyc;
    end
    if (rd_enable !== 1'b1 && prev_rd === 1'b1) rd_fall_cyc <= cyc;
    if (s_if.tready === 1'b1 && prev_tr !== 1'b1) tr_rise_cyc <= cyc;
    prev_rd <= rd_enable;
    prev_tr <= s_if.tready;
  end

  function automatic logic [ADDR_W-1:0] exp_addr(input int i);
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] r;
    a = ADDR_W'(i);
    r = a;
`ifdef FFT_BITREV_EN
    for (int b = 0; b < ADDR_W; b++) r[b] = a[ADDR_W-1-b];
`endif
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] bin_word(input int i);
    return {16'(i), 16'(i)};
  endfunction

  task automatic do_reset();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // Present one bin and wait (bounded) until it is accepted; acc = cycle of the beat.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk);
      if (s_if.tready === 1'b1) begin
        acc  = cyc;
        done = 1'b1;
      end
    end
    if (done) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: tready stayed %b, required 1 within 5000 cycles", s_if.tready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (ram_we !== 1'b0)    begin errors++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    checks++; if (ram_waddr !== '0)   begin errors++; $display("FAIL rst_waddr: got %0d want 0", ram_waddr); end
    checks++; if (ram_wdata !== '0)   begin errors++; $display("FAIL rst_wdata: got %h want 0", ram_wdata); end
    checks++; if (rd_enable !== 1'b0) begin errors++; $display("FAIL rst_rd_enable: got %b want 0", rd_enable); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b want 1", s_if.tready); end
  endtask

  task automatic test_good_frame();
    int w0, e0, r0, acc, last_cyc, bad, bad_i;
    do_reset();
    w0 = wa_q.size(); e0 = err_total; r0 = rd_rises;
    last_cyc = -1;
    for (int i = 0; i < NBINS; i++) begin
      send_beat(bin_word(i), (i == NBINS - 1), acc);
      last_cyc = acc;
    end
    idle();
    repeat (RD_HOLD + 13) @(posedge clk);
    #1;
    checks++; if (wa_q.size() - w0 !== NBINS) begin errors++; $display("FAIL good_writes: got %0d want %0d", wa_q.size() - w0, NBINS); end
    bad = 0; bad_i = -1;
    for (int i = 0; i < NBINS && w0 + i < wa_q.size(); i++)
      if (wa_q[w0+i] !== exp_addr(i) || wd_q[w0+i] !== bin_word(i)) begin bad++; if (bad_i < 0) bad_i = i; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL good_addr_data: %0d bad writes, first at beat %0d, want 0 bad", bad, bad_i); end
`ifdef FFT_BITREV_EN
    checks++; if (wa_q[w0+1] !== 10'd512) begin errors++; $display("FAIL bitrev_1: got %0d want 512", wa_q[w0+1]); end
    checks++; if (wa_q[w0+3] !== 10'd768) begin errors++; $display("FAIL bitrev_3: got %0d want 768", wa_q[w0+3]); end
`endif
    checks++; if (rd_rises - r0 !== 1) begin errors++; $display("FAIL good_rd_rises: got %0d want 1", rd_rises - r0); end
    checks++; if (rd_rise_cyc !== last_cyc + 2) begin errors++; $display("FAIL good_rd_rise: got cycle %0d want %0d", rd_rise_cyc, last_cyc + 2); end
    checks++; if (rd_fall_cyc - rd_rise_cyc !== RD_HOLD) begin errors++; $display("FAIL good_rd_hold: got %0d want %0d", rd_fall_cyc - rd_rise_cyc, RD_HOLD); end
    checks++; if (tr_rise_cyc !== rd_fall_cyc + GAP_CYCLES) begin errors++; $display("FAIL good_tready_rise: got cycle %0d want %0d", tr_rise_cyc, rd_fall_cyc + GAP_CYCLES); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL good_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (err_total - e0 !== 0) begin errors++; $display("FAIL good_frame_err: got %0d pulses want 0", err_total - e0); end
    checks++; if (we_during_rd !== 0) begin errors++; $display("FAIL good_we_during_rd: got %0d want 0", we_during_rd); end
  endtask

  task automatic test_short_frame();
    int w0, e0, r0, acc, bad;
    do_reset();
    w0 = wa_q.size(); e0 = err_total; r0 = rd_rises;
    for (int i = 0; i < 100; i++) send_beat(bin_word(i), (i == 99), acc);
    idle();
    repeat (10) @(posedge clk);
    #1;
    checks++; if (wa_q.size() - w0 !== 100) begin errors++; $display("FAIL short_writes: got %0d want 100", wa_q.size() - w0); end
    checks++; if (err_total - e0 !== 1) begin errors++; $display("FAIL short_frame_err: got %0d pulses want 1", err_total - e0); end
    checks++; if (rd_rises - r0 !== 0) begin errors++; $display("FAIL short_no_trigger: got %0d rises want 0", rd_rises - r0); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL short_frame_cnt: got %0d want 0", frame_cnt); end
    w0 = wa_q.size(); r0 = rd_rises;
    for (int i = 0; i < NBINS; i++) send_beat(bin_word(i), (i == NBINS - 1), acc);
    idle();
    repeat (RD_HOLD + 13) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < NBINS && w0 + i < wa_q.size(); i++)
      if (wa_q[w0+i] !== exp_addr(i)) bad++;
    checks++; if (bad !== 0 || wa_q.size() - w0 !== NBINS) begin errors++; $display("FAIL short_next_addr: %0d bad of %0d writes, want 0 of %0d", bad, wa_q.size() - w0, NBINS); end
    checks++; if (rd_rises - r0 !== 1) begin errors++; $display("FAIL short_next_trigger: got %0d rises want 1", rd_rises - r0); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL short_next_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_long_frame();
    int w0, e0, r0, acc, bad;
    do_reset();
    w0 = wa_q.size(); e0 = err_total; r0 = rd_rises;
    for (int i = 0; i < NBINS + 6; i++) send_beat(bin_word(i), (i == NBINS + 5), acc);
    idle();
    repeat (10) @(posedge clk);
    #1;
    checks++; if (wa_q.size() - w0 !== NBINS) begin errors++; $display("FAIL long_writes: got %0d want %0d", wa_q.size() - w0, NBINS); end
    bad = 0;
    for (int i = 0; i < NBINS && w0 + i < wa_q.size(); i++)
      if (wa_q[w0+i] !== exp_addr(i) || wd_q[w0+i] !== bin_word(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL long_addr_data: got %0d bad writes want 0", bad); end
    checks++; if (err_total - e0 !== 1) begin errors++; $display("FAIL long_frame_err: got %0d pulses want 1", err_total - e0); end
    checks++; if (rd_rises - r0 !== 0) begin errors++; $display("FAIL long_no_trigger: got %0d rises want 0", rd_rises - r0); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL long_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL long_tready: got %b want 1", s_if.tready); end
  endtask

  task automatic test_backpressure();
    int w0, r0, acc;
    do_reset();
    w0 = wa_q.size(); r0 = rd_rises;
    for (int i = 0; i < NBINS; i++) send_beat(bin_word(i), (i == NBINS - 1), acc);
    // Keep a bin pending through READOUT and GAP
    send_beat(32'hCAFE_0001, 1'b0, acc);
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (acc !== tr_rise_cyc) begin errors++; $display("FAIL bp_first_accept: got cycle %0d want %0d", acc, tr_rise_cyc); end
    checks++; if (wa_q.size() - w0 !== NBINS + 1) begin errors++; $display("FAIL bp_writes: got %0d want %0d", wa_q.size() - w0, NBINS + 1); end
    checks++; if (wa_q[$] !== exp_addr(0) || wd_q[$] !== 32'hCAFE_0001) begin errors++; $display("FAIL bp_new_write: got addr %0d data %h want addr %0d data cafe0001", wa_q[$], wd_q[$], exp_addr(0)); end
    checks++; if (rd_rises - r0 !== 1) begin errors++; $display("FAIL bp_rd_rises: got %0d want 1", rd_rises - r0); end
    checks++; if (we_during_rd !== 0) begin errors++; $display("FAIL bp_we_during_rd: got %0d want 0", we_during_rd); end
  endtask

  task automatic test_gapped_reset();
    int w0, acc, bad;
    do_reset();
    w0 = wa_q.size();
    for (int i = 0; i < 500; i++) begin
      idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_beat(bin_word(i), 1'b0, acc);
    end
    s_if.tdata  = bin_word(500);
    s_if.tvalid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ram_we !== 1'b0 || ram_waddr !== '0 || ram_wdata !== '0) begin errors++; $display("FAIL midrst_ram: got we %b addr %0d data %h want 0 0 0", ram_we, ram_waddr, ram_wdata); end
    checks++; if (rd_enable !== 1'b0 || frame_err !== 1'b0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_status: got rd %b err %b cnt %0d want 0 0 0", rd_enable, frame_err, frame_cnt); end
    checks++; if (wa_q.size() - w0 !== 500) begin errors++; $display("FAIL gap_writes: got %0d want 500", wa_q.size() - w0); end
    bad = 0;
    for (int i = 0; i < 500 && w0 + i < wa_q.size(); i++)
      if (wa_q[w0+i] !== exp_addr(i) || wd_q[w0+i] !== bin_word(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL gap_contiguous: got %0d bad writes want 0", bad); end
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    w0 = wa_q.size();
    for (int i = 0; i < 4; i++) send_beat(32'h1111_0000 + 32'(i), 1'b0, acc);
    idle();
    repeat (2) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 4 && w0 + i < wa_q.size(); i++)
      if (wa_q[w0+i] !== exp_addr(i) || wd_q[w0+i] !== 32'h1111_0000 + 32'(i)) bad++;
    checks++; if (bad !== 0 || wa_q.size() - w0 !== 4) begin errors++; $display("FAIL fresh_frame: %0d bad of %0d writes, want 0 of 4", bad, wa_q.size() - w0); end
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_backpressure();
    test_gapped_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
